// File: rtl/pll_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_seq_pkg
// Shared definitions for the PLL sequencer CSR block: channel FSM state
// encoding, CSR opcode offsets relative to the block base, and the maximum
// number of PLL channels the register layout can hold.
// ---------------------------------------------------------------------------
package pll_seq_pkg;

    // Register fields are laid out as four channel bits per nibble.
    localparam int MAX_PLLS = 4;

    // Opcode offsets from PLL_CSR_BASE.
    localparam logic [7:0] OFS_CTRL   = 8'd0;
    localparam logic [7:0] OFS_STATUS = 8'd1;
    localparam logic [7:0] OFS_CLR    = 8'd2;
    localparam logic [7:0] OFS_STATE  = 8'd3;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_PWRUP  = 3'd1,
        ST_LOCKED = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FAULT  = 3'd4
    } pll_state_e;

    // 2-bit code reported in the STATE register. FAULT reads as 0; software
    // tells it apart from OFF through the fault bit in STATUS.
    function automatic logic [1:0] state_code(input pll_state_e s);
        return (s == ST_FAULT) ? 2'd0 : s[1:0];
    endfunction

endpackage

// File: rtl/pll_seq_channel.sv
// ---------------------------------------------------------------------------
// pll_seq_channel
// One PLL channel: lock synchroniser, saturating timer, power sequencing FSM
// and its registered outputs. All state updates on the falling SPI clock edge.
//
// Ports
//   spi_clock_in      SPI clock (falling edge active)
//   spi_reset_n_in    asynchronous active-low reset
//   pll_locked_i      raw PLL lock, asynchronous to spi_clock_in
//   en_req_i          enable request from the CTRL register
//   rd_req_i          SPI-read request from the CTRL register
//   clr_i             one-cycle fault clear strobe
//   lock_s_o          synchronised lock
//   fault_o           registered fault flag
//   fault_d_o         fault flag the channel will hold after the next edge
//   pllpowerdown_n_o  1 = PLL powered
//   read_en_o         1 = SPI clock reads the image buffer
//   state_code_o      2-bit state code for the STATE register
// ---------------------------------------------------------------------------
module pll_seq_channel
    import pll_seq_pkg::*;
#(
    parameter int LOCK_SYNC_STAGES = 2,
    parameter int LOCK_TIMEOUT     = 255,
    parameter int SWITCH_SETTLE    = 4
) (
    input  logic       spi_clock_in,
    input  logic       spi_reset_n_in,
    input  logic       pll_locked_i,
    input  logic       en_req_i,
    input  logic       rd_req_i,
    input  logic       clr_i,
    output logic       lock_s_o,
    output logic       fault_o,
    output logic       fault_d_o,
    output logic       pllpowerdown_n_o,
    output logic       read_en_o,
    output logic [1:0] state_code_o
);

    localparam int TIMER_TOP = (LOCK_TIMEOUT > SWITCH_SETTLE) ? LOCK_TIMEOUT : SWITCH_SETTLE;
    localparam int TW        = $clog2(TIMER_TOP + 1);

    localparam logic [TW-1:0] TIMER_SAT    = '1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] SETTLE_LAST  = TW'(SWITCH_SETTLE - 1);

    logic [LOCK_SYNC_STAGES-1:0] sync_q;
    pll_state_e                  state_q, state_d;
    logic [TW-1:0]               timer_q, timer_d;
    logic                        pd_n_q, read_en_q, fault_q;
    logic                        lock_s;

    assign lock_s = sync_q[LOCK_SYNC_STAGES-1];

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        // Free-running saturating count; cleared on entry to the timed states.
        timer_d = (timer_q == TIMER_SAT) ? timer_q : timer_q + TW'(1);
        case (state_q)
            ST_OFF: begin
                if (en_req_i) begin
                    state_d = ST_PWRUP;
                    timer_d = '0;
                end
            end
            ST_PWRUP: begin
                // Lock is checked first so a lock arriving on the timeout
                // cycle is not reported as a fault.
                if (lock_s)                        state_d = ST_LOCKED;
                else if (!en_req_i)                state_d = ST_OFF;
                else if (timer_q == TIMEOUT_LAST)  state_d = ST_FAULT;
            end
            ST_LOCKED: begin
                // Losing lock outranks a disable request.
                if (!lock_s) begin
                    state_d = ST_FAULT;
                end else if (!en_req_i) begin
                    state_d = ST_DRAIN;
                    timer_d = '0;
                end
            end
            ST_DRAIN: begin
                // Runs to completion even if re-enabled meanwhile.
                if (timer_q == SETTLE_LAST) state_d = ST_OFF;
            end
            ST_FAULT: begin
                if (clr_i) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(negedge spi_clock_in or negedge spi_reset_n_in) begin
        if (!spi_reset_n_in) begin
            sync_q    <= '0;
            state_q   <= ST_OFF;
            timer_q   <= '0;
            pd_n_q    <= 1'b0;
            read_en_q <= 1'b1;
            fault_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[LOCK_SYNC_STAGES-2:0], pll_locked_i};
            state_q <= state_d;
            timer_q <= timer_d;
            // Outputs follow the next state so they move on the same edge
            // as the state. The buffer is only handed back to the SPI clock
            // off-LOCKED, which keeps read_en high whenever the PLL is down.
            pd_n_q    <= (state_d == ST_PWRUP) || (state_d == ST_LOCKED) || (state_d == ST_DRAIN);
            read_en_q <= (state_d == ST_LOCKED) ? rd_req_i : 1'b1;
            fault_q   <= (state_d == ST_FAULT);
        end
    end

    assign lock_s_o         = lock_s;
    assign fault_o          = fault_q;
    assign fault_d_o        = (state_d == ST_FAULT);
    assign pllpowerdown_n_o = pd_n_q;
    assign read_en_o        = read_en_q;
    assign state_code_o     = state_code(state_q);

endmodule

// File: rtl/pll_seq_csr.sv
// ---------------------------------------------------------------------------
// pll_seq_csr
// CSR front end for up to four PLL channels. Decodes four opcodes from
// PLL_CSR_BASE: CTRL (write en/rd masks), STATUS (read lock/fault),
// CLR (write fault clear), STATE (read per-channel state codes).
//
// Ports
//   spi_clock_in          SPI clock, falling edge active
//   spi_reset_n_in        asynchronous active-low reset
//   opcode_in             register opcode
//   operand_in            write data
//   operand_valid_in      write qualifier, one cycle
//   response_out          combinational read data
//   pllpowerdown_n        per channel, 1 = PLL on (registered)
//   image_buffer_read_en  per channel, 1 = SPI clock reads image buffer
//   pll_locked            raw PLL lock inputs (asynchronous)
//   fault_out             OR of all channel fault flags (registered)
// ---------------------------------------------------------------------------
module pll_seq_csr
    import pll_seq_pkg::*;
#(
    parameter logic [7:0] PLL_CSR_BASE     = 8'h40,
    parameter int         NUM_PLLS         = 1,
    parameter logic [3:0] EN_DEFAULT       = 4'b0001,
    parameter int         LOCK_SYNC_STAGES = 2,
    parameter int         LOCK_TIMEOUT     = 255,
    parameter int         SWITCH_SETTLE    = 4
) (
    input  logic                spi_clock_in,
    input  logic                spi_reset_n_in,
    input  logic [7:0]          opcode_in,
    input  logic [7:0]          operand_in,
    input  logic                operand_valid_in,
    output logic [7:0]          response_out,
    output logic [NUM_PLLS-1:0] pllpowerdown_n,
    output logic [NUM_PLLS-1:0] image_buffer_read_en,
    input  logic [NUM_PLLS-1:0] pll_locked,
    output logic                fault_out
);

    localparam logic [7:0] ADDR_CTRL   = PLL_CSR_BASE + OFS_CTRL;
    localparam logic [7:0] ADDR_STATUS = PLL_CSR_BASE + OFS_STATUS;
    localparam logic [7:0] ADDR_CLR    = PLL_CSR_BASE + OFS_CLR;
    localparam logic [7:0] ADDR_STATE  = PLL_CSR_BASE + OFS_STATE;

    logic                     ctrl_wr, clr_wr;
    logic [NUM_PLLS-1:0]      en_req_q, rd_req_q, clr;
    logic [NUM_PLLS-1:0]      lock_s, fault_flag, fault_next;
    logic [NUM_PLLS-1:0][1:0] ch_code;
    logic                     fault_out_q;
    logic                     unused_operand;

    assign ctrl_wr = operand_valid_in && (opcode_in == ADDR_CTRL);
    assign clr_wr  = operand_valid_in && (opcode_in == ADDR_CLR);
    // The clear strobe goes straight to the channels so FAULT leaves on the
    // same edge that accepts the write.
    assign clr     = clr_wr ? operand_in[NUM_PLLS-1:0] : '0;

    // Mask bits above NUM_PLLS are accepted on the bus and dropped.
    assign unused_operand = ^operand_in;

    always_ff @(negedge spi_clock_in or negedge spi_reset_n_in) begin
        if (!spi_reset_n_in) begin
            en_req_q    <= EN_DEFAULT[NUM_PLLS-1:0];
            rd_req_q    <= '0;
            fault_out_q <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                en_req_q <= operand_in[NUM_PLLS-1:0];
                rd_req_q <= operand_in[MAX_PLLS +: NUM_PLLS];
            end
            // Built from next-state flags so it rises with the channel flag.
            fault_out_q <= |fault_next;
        end
    end

    for (genvar g = 0; g < NUM_PLLS; g++) begin : g_ch
        pll_seq_channel #(
            .LOCK_SYNC_STAGES (LOCK_SYNC_STAGES),
            .LOCK_TIMEOUT     (LOCK_TIMEOUT),
            .SWITCH_SETTLE    (SWITCH_SETTLE)
        ) u_ch (
            .spi_clock_in     (spi_clock_in),
            .spi_reset_n_in   (spi_reset_n_in),
            .pll_locked_i     (pll_locked[g]),
            .en_req_i         (en_req_q[g]),
            .rd_req_i         (rd_req_q[g]),
            .clr_i            (clr[g]),
            .lock_s_o         (lock_s[g]),
            .fault_o          (fault_flag[g]),
            .fault_d_o        (fault_next[g]),
            .pllpowerdown_n_o (pllpowerdown_n[g]),
            .read_en_o        (image_buffer_read_en[g]),
            .state_code_o     (ch_code[g])
        );
    end

    always_comb begin
        response_out = '0;
        case (opcode_in)
            ADDR_STATUS: begin
                for (int i = 0; i < NUM_PLLS; i++) begin
                    response_out[i]            = lock_s[i];
                    response_out[MAX_PLLS + i] = fault_flag[i];
                end
            end
            ADDR_STATE: begin
                for (int i = 0; i < NUM_PLLS; i++) begin
                    response_out[2*i +: 2] = ch_code[i];
                end
            end
            default: ;
        endcase
    end

    assign fault_out = fault_out_q;

endmodule

// File: doc/pll_seq_csr.md
PLL_SEQ_CSR -- requirements
Module: pll_seq_csr

Interface
REQ-001 The parameter PLL_CSR_BASE SHALL default to 'h40 and set the opcode base; the block decodes BASE, BASE+1, BASE+2 and BASE+3.
REQ-002 The parameter NUM_PLLS SHALL default to 1, have a legal range of 1..4, and set the channel count.
REQ-003 The parameter EN_DEFAULT SHALL default to 4'b0001 and set the reset value of the per-channel enable-request mask.
REQ-004 The parameter LOCK_SYNC_STAGES SHALL default to 2, have a minimum of 2, and set the synchroniser depth for pll_locked.
REQ-005 The parameter LOCK_TIMEOUT SHALL default to 255 and set the number of spi_clock_in cycles allowed to reach lock.
REQ-006 The parameter SWITCH_SETTLE SHALL default to 4 and set the number of cycles the image-buffer clock switch is held before PLL power-down.
REQ-007 The port spi_clock_in SHALL be an input, 1 bit wide, carrying the SPI clock; all state updates on its falling edge.
REQ-008 The port spi_reset_n_in SHALL be an input, 1 bit wide, carrying the reset: asynchronous, active-low.
REQ-009 The port opcode_in SHALL be an input, 8 bits wide, carrying the register opcode.
REQ-010 The port operand_in SHALL be an input, 8 bits wide, carrying the write data.
REQ-011 The port operand_valid_in SHALL be an input, 1 bit wide, that qualifies a write for one cycle.
REQ-012 The port response_out SHALL be an output, 8 bits wide, carrying combinational read data.
REQ-013 The port pllpowerdown_n SHALL be an output, NUM_PLLS bits wide and registered, where per channel 1 = PLL on.
REQ-014 The port image_buffer_read_en SHALL be an output, NUM_PLLS bits wide and registered, where per channel 1 = SPI clock reads the image buffer.
REQ-015 The port pll_locked SHALL be an input, NUM_PLLS bits wide, that is asynchronous to spi_clock_in.
REQ-016 The port fault_out SHALL be an output, 1 bit wide and registered, that is the OR of all channel fault flags.

Function
REQ-017 A write to BASE (operand_valid_in & opcode_in==BASE) SHALL load the enable-request mask from operand_in[i] and the SPI-read-request mask from operand_in[4+i]; bits for i>=NUM_PLLS are ignored.
REQ-018 A write to BASE+2 SHALL clear the fault flag of channel i when operand_in[i]=1; a clear issued while the channel is not in FAULT has no effect.
REQ-019 A read of BASE+1 SHALL return the synchronised lock bit for channel i in bit i and the fault flag in bit 4+i; a read of BASE+3 SHALL return 2-bit state codes, channel i in bits [2i+1:2i]; other opcodes return 0, and unused bits return 0.
REQ-020 Each pll_locked bit SHALL pass through a LOCK_SYNC_STAGES-deep synchroniser (lock_s) before any use.
REQ-021 The per-channel FSM SHALL have the states OFF=0, PWRUP=1, LOCKED=2, DRAIN=3 and FAULT, and BASE+3 SHALL report FAULT as code 0 with the fault bit also set.
REQ-022 In OFF, pllpowerdown_n=0 and read_en=1; OFF SHALL go to PWRUP when en_req=1, clearing the timer.
REQ-023 In PWRUP, pllpowerdown_n=1 and read_en=1; PWRUP SHALL go to LOCKED on lock_s, to OFF on !en_req, and to FAULT when the timer reaches LOCK_TIMEOUT-1; if lock and timeout occur in the same cycle, LOCKED wins.
REQ-024 In LOCKED, pllpowerdown_n=1 and read_en=rd_req; LOCKED SHALL go to FAULT on !lock_s, and to DRAIN on !en_req with the timer cleared; if both occur in the same cycle, FAULT wins.
REQ-025 In DRAIN, pllpowerdown_n=1 and read_en=1; DRAIN SHALL go to OFF after SWITCH_SETTLE cycles, and re-enabling during DRAIN SHALL NOT abort it (the channel re-enters PWRUP from OFF).
REQ-026 In FAULT, pllpowerdown_n=0, read_en=1 and fault=1; FAULT SHALL go to OFF on clear, and then to PWRUP if en_req is still set.
REQ-027 Outputs SHALL be registered from the next state, so an output changes on the same edge as the state change.
REQ-028 read_en SHALL NOT go to 0 while pllpowerdown_n=0, in any cycle.
REQ-029 The timer width SHALL be $clog2(max(LOCK_TIMEOUT,SWITCH_SETTLE)+1) and the timer SHALL saturate with no wrap.

Reset
REQ-030 On reset the block SHALL set: state OFF, pllpowerdown_n=0, image_buffer_read_en=all 1s, fault flags 0, fault_out 0, synchronisers 0, en_req=EN_DEFAULT[NUM_PLLS-1:0], rd_req=0.
REQ-031 A reset assertion in any state SHALL force the reset values immediately, with no DRAIN sequence.

Structure
REQ-032 The state enum, the opcode offsets (CTRL=0, STATUS=1, CLR=2, STATE=3) and the max-channel constant SHALL live in pll_seq_pkg.
REQ-033 The sub-module pll_seq_channel SHALL contain the synchroniser, timer, FSM and output registers, and the top level SHALL generate NUM_PLLS instances plus CSR decode.

Verification
REQ-034 With BASE='h40, NUM_PLLS=2, LOCK_TIMEOUT=16 and SWITCH_SETTLE=4, the bench SHALL run the following scenarios:
- Reset, then pll_locked=2'b01 -> ch0 goes OFF->PWRUP; BASE+1 reads 'h01 within 3 cycles; BASE+3 reads 'h02 (ch0 LOCKED); ch1 pllpowerdown_n=0.
- Write 'h40<-'h11 while ch0 LOCKED -> image_buffer_read_en[0]=1; then write 'h00 -> read_en stays 1, pllpowerdown_n[0] falls exactly 4 cycles after DRAIN entry plus 1.
- Write 'h02 with pll_locked[1]=0 -> FAULT after 16 cycles; BASE+1 reads 'h20; fault_out=1; write 'h42<-'h02 -> returns OFF->PWRUP.
- ch0 LOCKED, pll_locked[0] drops together with write 'h40<-'h00 -> FAULT, not DRAIN.
- ch1 in PWRUP: timeout cycle coincides with lock_s rising -> LOCKED, fault stays 0.
- Reset asserted mid-DRAIN -> pllpowerdown_n=0 and read_en=1 immediately; en_req returns to EN_DEFAULT.
